dmem_responder: RTL and testbench

- Data-memory responder (slave end) for the pipeline's load/store request interface; the MEM stage is the initiator.
- Accepts one request at a time over a valid/ready channel and models a word-organised 64-bit RAM with configurable access latency.
- Performs RV64 byte-lane store merging and load extraction with sign/zero extension, keyed by funct3.
- Returns data or a write acknowledge, plus an error flag, over a valid/ready response channel.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the MEM stage
// (master, the initiator) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_rdata_o;
  logic        resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time against a
// word-organised 64-bit RAM, with fixed access latency, RV64 byte-lane
// store merging, and sign/zero-extended load extraction keyed by funct3.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic            lat_we;
  logic [63:0]     lat_addr;
  logic [63:0]     lat_wdata;
  logic [2:0]      lat_f3;

  logic [63:0]     rdata;
  logic            err;

  logic [63:0]     mem [DEPTH_WORDS];

  logic [63:0]     off;
  logic [AW-1:0]   idx;
  logic [2:0]      bo;
  logic [2:0]      amask;
  logic            bad_range;
  logic            bad_align;
  logic            bad_f3;
  logic            acc_err;
  logic [63:0]     cur_word;
  logic            finish;

  // Shift the addressed word down to the access offset, keep the access
  // size, then sign-extend unless funct3[2] asks for the unsigned form.
  function automatic logic [63:0] load_extract(input logic [63:0] word,
                                               input logic [2:0]  boff,
                                               input logic [2:0]  f3);
    logic [63:0] sh;
    sh = word >> {boff, 3'b000};
    case (f3[1:0])
      2'b00:   return f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   return f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   return f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // Replace only the bytes covered by the access; the store data arrives
  // right-aligned so it is moved up to the byte offset first.
  function automatic logic [63:0] store_merge(input logic [63:0] word,
                                              input logic [63:0] wdata,
                                              input logic [2:0]  boff,
                                              input logic [1:0]  size);
    logic [63:0] sh;
    logic [7:0]  be;
    logic [63:0] res;
    sh = wdata << {boff, 3'b000};
    case (size)
      2'b00:   be = 8'h01;
      2'b01:   be = 8'h03;
      2'b10:   be = 8'h0F;
      default: be = 8'hFF;
    endcase
    be = be << boff;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = be[b] ? sh[8*b +: 8] : word[8*b +: 8];
    end
    return res;
  endfunction

  assign finish = (state == BUSY) && (cnt == '0);

  // Decode and validate the latched request; the array read is combinational.
  always_comb begin
    off       = lat_addr - BASE_ADDR;
    idx       = off[AW+2:3];
    bo        = off[2:0];
    case (lat_f3[1:0])
      2'b00:   amask = 3'b000;
      2'b01:   amask = 3'b001;
      2'b10:   amask = 3'b011;
      default: amask = 3'b111;
    endcase
    bad_range = (lat_addr < BASE_ADDR) || ((off >> 3) >= 64'(DEPTH_WORDS));
    bad_align = |(bo & amask);
    bad_f3    = lat_we ? lat_f3[2] : (lat_f3 == 3'b111);
    acc_err   = bad_range || bad_align || bad_f3;
    cur_word  = mem[idx];
  end

  // Next-state logic: accept in IDLE, count down in BUSY, wait for handshake in RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid_i) begin
          state_nxt = BUSY;
          cnt_nxt   = CW'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and latency counter; reset abandons any in-flight request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request on the accept edge so later req_* changes are ignored.
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.req_valid_i) begin
      lat_we    <= bus.req_we_i;
      lat_addr  <= bus.req_addr_i;
      lat_wdata <= bus.req_wdata_i;
      lat_f3    <= bus.req_funct3_i;
    end
  end

  // Register the response when the access completes; held through RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (finish) begin
      err   <= acc_err;
      rdata <= (acc_err || lat_we) ? 64'd0 : load_extract(cur_word, bo, lat_f3);
    end
  end

  // Array write: only legal stores, on the completing edge of BUSY.
  always_ff @(posedge clock) begin
    if (finish && lat_we && !acc_err) begin
      mem[idx] <= store_merge(cur_word, lat_wdata, bo, lat_f3[1:0]);
    end
  end

  assign bus.req_ready_o  = (state == IDLE);
  assign bus.resp_valid_o = (state == RESP);
  assign bus.resp_rdata_o = rdata;
  assign bus.resp_err_o   = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of load/store requests
// with hand-computed responses, then backpressure and reset-in-flight cases.
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(2),
    .BASE_ADDR(64'h8000_0000)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  f3;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; lat is the cycle count from accept edge to resp_valid.
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [2:0] f3, output logic [63:0] rd, output logic er,
                        output int lat, output logic rdy_after);
    int n;
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_funct3_i = f3;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = ~we;
    bus.req_addr_i   = ~addr;
    bus.req_wdata_i  = ~wdata;
    bus.req_funct3_i = ~f3;
    n = 0;
    while (bus.resp_valid_o !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    rd  = bus.resp_rdata_o;
    er  = bus.resp_err_o;
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    rdy_after = bus.req_ready_o;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic        rdy;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 3'b011, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'h8000_0008, 64'h0, 3'b011, 64'h1122_3344_5566_7788, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0009, 64'h80, 3'b000, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 64'h8000_0009, 64'h0, 3'b000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[4]  = '{1'b0, 64'h8000_0009, 64'h0, 3'b100, 64'h80, 1'b0};
    vecs[5]  = '{1'b0, 64'h8000_0008, 64'h0, 3'b011, 64'h1122_3344_5566_8088, 1'b0};
    vecs[6]  = '{1'b0, 64'h8000_000A, 64'h0, 3'b010, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 64'h8000_000A, 64'hDEAD_BEEF, 3'b010, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 64'h8000_0008, 64'h0, 3'b011, 64'h1122_3344_5566_8088, 1'b0};
    vecs[9]  = '{1'b0, 64'h7FFF_FFF8, 64'h0, 3'b011, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 64'h8000_2000, 64'h0, 3'b011, 64'h0, 1'b1};
    vecs[11] = '{1'b0, 64'h8000_0008, 64'h0, 3'b111, 64'h0, 1'b1};
    vecs[12] = '{1'b0, 64'h8000_000E, 64'h0, 3'b001, 64'h1122, 1'b0};
    vecs[13] = '{1'b0, 64'h8000_000C, 64'h0, 3'b010, 64'h1122_3344, 1'b0};
    vecs[14] = '{1'b1, 64'h8000_000C, 64'hFFFF_ABCD, 3'b001, 64'h0, 1'b0};
    vecs[15] = '{1'b0, 64'h8000_000C, 64'h0, 3'b001, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0};
    vecs[16] = '{1'b0, 64'h8000_000C, 64'h0, 3'b101, 64'hABCD, 1'b0};
    vecs[17] = '{1'b0, 64'h8000_0008, 64'h0, 3'b011, 64'h1122_ABCD_5566_8088, 1'b0};
    vecs[18] = '{1'b1, 64'h8000_0010, 64'hCAFE_F00D_8765_4321, 3'b011, 64'h0, 1'b0};
    vecs[19] = '{1'b0, 64'h8000_0010, 64'h0, 3'b010, 64'hFFFF_FFFF_8765_4321, 1'b0};
    vecs[20] = '{1'b0, 64'h8000_0010, 64'h0, 3'b110, 64'h8765_4321, 1'b0};
    vecs[21] = '{1'b0, 64'h8000_0014, 64'h0, 3'b010, 64'hFFFF_FFFF_CAFE_F00D, 1'b0};
    vecs[22] = '{1'b1, 64'h8000_0010, 64'h0, 3'b100, 64'h0, 1'b1};
    vecs[23] = '{1'b1, 64'h8000_0014, 64'h0, 3'b011, 64'h0, 1'b1};
    vecs[24] = '{1'b1, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 3'b011, 64'h0, 1'b0};
    vecs[25] = '{1'b0, 64'h8000_1FF8, 64'h0, 3'b011, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[26] = '{1'b0, 64'h8000_0010, 64'h0, 3'b011, 64'hCAFE_F00D_8765_4321, 1'b0};

    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_funct3_i = '0;
    bus.resp_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("reset_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("reset_rdata", bus.resp_rdata_o, 64'd0);
    check("reset_err", 64'(bus.resp_err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat, rdy);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_ready_after", i), 64'(rdy), 64'd1);
    end

    // Backpressure: response held 5 cycles while a new request is ignored.
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = 64'h8000_0008;
    bus.req_funct3_i = 3'b011;
    @(posedge clk);
    #1;
    bus.req_we_i     = 1'b1;
    bus.req_wdata_i  = 64'h0;
    n = 0;
    while (bus.resp_valid_o !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_latency", 64'(n), 64'd2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_c%0d", c), 64'(bus.resp_valid_o), 64'd1);
      check($sformatf("bp_rdata_c%0d", c), bus.resp_rdata_o, 64'h1122_ABCD_5566_8088);
      check($sformatf("bp_req_ready_c%0d", c), 64'(bus.req_ready_o), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    check("bp_release_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("bp_release_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    do_txn(1'b0, 64'h8000_0008, 64'h0, 3'b011, rd, er, lat, rdy);
    check("bp_ignored_store_rdata", rd, 64'h1122_ABCD_5566_8088);

    // Load leaves nonzero rdata registered, then reset lands mid-BUSY of a store.
    do_txn(1'b0, 64'h8000_0010, 64'h0, 3'b011, rd, er, lat, rdy);
    check("pre_reset_rdata", rd, 64'hCAFE_F00D_8765_4321);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_addr_i   = 64'h8000_0010;
    bus.req_wdata_i  = 64'h5555_AAAA_5555_AAAA;
    bus.req_funct3_i = 3'b011;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    check("busy_req_ready", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("midreset_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("midreset_rdata", bus.resp_rdata_o, 64'd0);
    check("midreset_err", 64'(bus.resp_err_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 64'h8000_0010, 64'h0, 3'b011, rd, er, lat, rdy);
    check("post_reset_latency", 64'(lat), 64'd2);
    check("post_reset_rdata", rd, 64'hCAFE_F00D_8765_4321);
    check("post_reset_err", 64'(er), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
